sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_small_sigma.sv | 20 ++
 rtl/sha256_msg_schedule.sv | 96 +++++++++
 tb/tb_sha256_msg_schedule.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message schedule.
// Holds the word width, the round count, the small-sigma rotate/shift
// amounts, the controller state encoding and a rotate-right helper.
package sha256_pkg;

  localparam int WORD_W     = 32;
  localparam int NUM_ROUNDS = 64;

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    SIGMA_S0 = 1'b0,
    SIGMA_S1 = 1'b1
  } sigma_sel_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma function, purely combinational.
// Ports:
//   i_x : input word
//   o_y : s0(i_x) when SEL = SIGMA_S0, s1(i_x) when SEL = SIGMA_S1
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter sigma_sel_t SEL = SIGMA_S0
) (
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);

  if (SEL == SIGMA_S0) begin : g_s0
    assign o_y = rotr(i_x, S0_ROT_A) ^ rotr(i_x, S0_ROT_B) ^ (i_x >> S0_SHR);
  end else begin : g_s1
    assign o_y = rotr(i_x, S1_ROT_A) ^ rotr(i_x, S1_ROT_B) ^ (i_x >> S1_SHR);
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator.
// Loads one 512-bit block into a 16-word sliding window and streams
// W_0..W_{NUM_ROUNDS-1} out with a valid/ready handshake, one word per
// cycle while the consumer is ready.
//
// state | meaning
// IDLE  | waiting for start; window holds last contents
// RUN   | window[0] presented as W_t, advances on each acceptance
// DONE  | one-cycle done pulse after the last word was accepted
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   start    : load block_in (only honoured in IDLE)
//   block_in : padded message block, M0 in [511:480]
//   w_ready  : consumer accepts w_out this cycle
//   w_out    : current schedule word W_t
//   w_valid  : w_out / w_idx are valid
//   w_idx    : round index t of w_out
//   busy     : high in RUN and DONE
//   done     : one-cycle pulse after the last word is accepted
// Only WORD_W = 32 is supported.
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
  parameter int WORD_W     = sha256_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [511:0]      block_in,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_out,
  output logic              w_valid,
  output logic [5:0]        w_idx,
  output logic              busy,
  output logic              done
);
  import sha256_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_win [16];
  logic [5:0]        r_t;

  logic              w_load;
  logic              w_accept;
  logic              w_last;
  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;
  logic [WORD_W-1:0] w_new;

  sha256_small_sigma #(.SEL(SIGMA_S0)) u_s0 (.i_x(r_win[1]),  .o_y(w_s0));
  sha256_small_sigma #(.SEL(SIGMA_S1)) u_s1 (.i_x(r_win[14]), .o_y(w_s1));

  // window[15] after shift: W_{t+16} from pre-shift window, mod 2^32
  assign w_new    = w_s1 + r_win[9] + w_s0 + r_win[0];
  assign w_load   = (r_state == IDLE) && start;
  assign w_accept = (r_state == RUN) && w_ready;
  assign w_last   = (r_t == 6'(NUM_ROUNDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_t     <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        for (int i = 0; i < 16; i++) r_win[i] <= block_in[511 - 32*i -: 32];
        r_t <= '0;
      end else if (w_accept) begin
        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
        r_win[15] <= w_new;
        // hold at the last index so w_idx never wraps
        if (!w_last) r_t <= r_t + 6'd1;
      end
    end
  end

  assign w_out   = r_win[0];
  assign w_idx   = r_t;
  assign w_valid = (r_state == RUN);
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic         w_ready;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [5:0]   w_idx;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [31:0]  model_w [64];
  logic [31:0]  cap     [64];
  logic [511:0] abc_blk;
  logic [511:0] zero_blk;
  logic [511:0] alt_blk;

  typedef struct {
    int          idx;
    logic [31:0] w;
  } vec_t;
  vec_t tbl [8];

  sha256_msg_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .w_valid  (w_valid),
    .w_idx    (w_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) model_w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      model_w[i] = ss1(model_w[i-2]) + model_w[i-7] + ss0(model_w[i-15]) + model_w[i-16];
  endtask

  // Assumes W0 is being presented now (sampled #1 after the start edge).
  // done_cyc counts the start edge as cycle 1.
  task automatic collect(input int stall_at, input int stall_len, input int inj_at,
                         output int done_cyc);
    int exp_t   = 0;
    int stalled = 0;
    int cyc     = 1;
    bit seen    = 0;
    bit injd    = 0;
    done_cyc = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done) begin
        seen     = 1;
        done_cyc = cyc;
        chk("valid_low_at_done", 32'(w_valid), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd1);
      end else begin
        if (exp_t > 63) begin
          chk("idx_overrun", exp_t, 63);
          break;
        end
        chk("w_valid", 32'(w_valid), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("w_idx", 32'(w_idx), exp_t);
        chk("w_out", w_out, model_w[exp_t]);
        w_ready = 1'b1;
        if (exp_t == stall_at && stalled < stall_len) begin
          w_ready = 1'b0;
          stalled++;
        end
        if (injd) start = 1'b0;
        if (exp_t == inj_at && !injd) begin
          start    = 1'b1;
          block_in = alt_blk;
          injd     = 1'b1;
        end
        if (w_ready) begin
          cap[exp_t] = w_out;
          exp_t++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    w_ready = 1'b1;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("words_accepted", exp_t, 64);
  endtask

  task automatic run_block(input logic [511:0] blk, input int stall_at, input int stall_len,
                           input int inj_at, input bit hold, output int done_cyc);
    block_in = blk;
    start    = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    collect(stall_at, stall_len, inj_at, done_cyc);
  endtask

  initial begin
    int dc;
    int pulses;
    int gap;

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    zero_blk = '0;
    alt_blk  = {16{32'hDEADBEEF}};

    tbl[0] = '{0,  32'h61626380};
    tbl[1] = '{1,  32'h00000000};
    tbl[2] = '{15, 32'h00000018};
    tbl[3] = '{16, 32'h61626380};
    tbl[4] = '{17, 32'h000F0000};
    tbl[5] = '{18, 32'h7DA86405};
    tbl[6] = '{19, 32'h600003C6};
    tbl[7] = '{63, 32'h12B1EDEB};

    rst      = 1'b0;
    start    = 1'b0;
    w_ready  = 1'b1;
    block_in = abc_blk;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_w_out", w_out, 32'd0);
    chk("rst_w_idx", 32'(w_idx), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // "abc" block, consumer always ready
    build_model(abc_blk);
    run_block(abc_blk, -1, 0, -1, 1'b0, dc);
    chk("abc_done_latency", dc, 65);
    for (int i = 0; i < 8; i++) chk($sformatf("abc_W%0d", tbl[i].idx), cap[tbl[i].idx], tbl[i].w);
    @(posedge clk); #1;
    chk("abc_done_one_cycle", 32'(done), 32'd0);
    chk("abc_idle_busy", 32'(busy), 32'd0);

    // all-zero block, done exactly once
    build_model(zero_blk);
    run_block(zero_blk, -1, 0, -1, 1'b0, dc);
    chk("zero_done_latency", dc, 65);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("zero_extra_done", pulses, 0);

    // "abc" with 5-cycle stall at t=20
    build_model(abc_blk);
    run_block(abc_blk, 20, 5, -1, 1'b0, dc);
    chk("stall_done_latency", dc, 70);
    @(posedge clk); #1;

    // start pulsed with a different block at t=10 is ignored
    run_block(abc_blk, -1, 0, 10, 1'b0, dc);
    chk("inj_done_latency", dc, 65);
    chk("inj_W63", cap[63], 32'h12B1EDEB);
    @(posedge clk); #1;

    // reset mid-run at t=30 aborts the block
    block_in = abc_blk;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_abort_idx", 32'(w_idx), 32'd30);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_w_valid", 32'(w_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    pulses = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done || w_valid) pulses++;
    end
    chk("abort_no_resume", pulses, 0);
    run_block(abc_blk, -1, 0, -1, 1'b0, dc);
    chk("after_abort_latency", dc, 65);
    chk("after_abort_W18", cap[18], 32'h7DA86405);
    @(posedge clk); #1;

    // start held high across two blocks
    run_block(abc_blk, -1, 0, -1, 1'b1, dc);
    chk("held1_done_latency", dc, 65);
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      gap++;
      if (w_valid) break;
    end
    chk("held_gap", gap, 2);
    collect(-1, 0, -1, dc);
    chk("held2_done_latency", dc, 65);
    chk("held2_W17", cap[17], 32'h000F0000);
    start = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
